// File: rtl/sqrl_uart_pkg.sv
// Shared definitions for the sqrl UART link: receiver state encoding,
// frame width and the baud divider helper used by both RX and TX.
package sqrl_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;

  // Clock cycles per bit minus one; both link ends must agree on this value.
  function automatic logic [15:0] uart_baud_delay(input int unsigned freq,
                                                  input int unsigned baud);
    int unsigned q;
    q = freq / baud - 1;
    return q[15:0];
  endfunction

endpackage

// File: rtl/sqrl_uart_recv_if.sv
// Byte-side bundle of the UART receiver: strobes, received byte and busy.
// master = receiver (drives), slave = consumer (command parser).
interface sqrl_uart_recv_if;
  logic       rx_new_byte;
  logic [7:0] rx_byte;
  logic       rx_frame_err;
  logic       rx_busy;

  modport master (
    output rx_new_byte,
    output rx_byte,
    output rx_frame_err,
    output rx_busy
  );

  modport slave (
    input rx_new_byte,
    input rx_byte,
    input rx_frame_err,
    input rx_busy
  );
endinterface

// File: rtl/sqrl_uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RESET_VAL so an idle line reads as idle out of reset.
module sqrl_uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sqrl_uart_recv.sv
// sqrl_uart_recv: 8N1 UART receiver. Synchronises uart_rx, locates the
// start bit, samples data (LSB first) and stop bit at bit centres and
// emits a one-cycle strobe per good byte or per framing error.
// Optional build macro: SQRL_UART_RX_MAJORITY_EN -- sample points take the
// 2-of-3 majority of the last three synchronised samples.
module sqrl_uart_recv
  import sqrl_uart_pkg::*;
#(
  parameter int unsigned comm_clk_frequency = 100000000,
  parameter int unsigned baud_rate          = 115200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  sqrl_uart_recv_if.master  rx_if
);

  localparam logic [15:0] BAUD_DELAY = uart_baud_delay(comm_clk_frequency, baud_rate);
  localparam logic [15:0] HALF_DELAY = BAUD_DELAY >> 1;
  localparam logic [2:0]  LAST_BIT   = 3'(UART_DATA_BITS - 1);

  generate
    if (comm_clk_frequency / baud_rate < 5) begin : g_bad_baud
      $error("sqrl_uart_recv: baud_delay must be at least 4");
    end
  endgenerate

  logic        rx_s;
  logic        rx_bit;
  uart_state_e state_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  rx_byte_q;
  logic        new_byte_q;
  logic        frame_err_q;

  sqrl_uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (uart_rx),
    .q     (rx_s)
  );

`ifdef SQRL_UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Keep the two previous synchronised samples for the majority vote.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign rx_bit = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign rx_bit = rx_s;
`endif

  assign cnt_d = cnt_q + 16'd1;

  // Receive FSM: bit timing counter, data shift and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      new_byte_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      new_byte_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= START;
        end
        START: begin
          if (cnt_q == HALF_DELAY) begin
            cnt_q <= '0;
            if (!rx_bit) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;  // glitch, not a real start bit
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DATA: begin
          if (cnt_q == BAUD_DELAY) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rx_bit;
            if (bit_idx_q == LAST_BIT) state_q <= STOP;
            else bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        STOP: begin
          if (cnt_q == BAUD_DELAY) begin
            cnt_q <= '0;
            if (rx_bit) begin
              rx_byte_q  <= shift_q;
              new_byte_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_IDLE: begin
          // Hold off until the line returns high so a break reports once.
          if (rx_s) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_if.rx_new_byte  = new_byte_q;
  assign rx_if.rx_byte      = rx_byte_q;
  assign rx_if.rx_frame_err = frame_err_q;
  assign rx_if.rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sqrl_uart_recv.sv
// Directed bench for sqrl_uart_recv at 16 clocks per bit.
module tb_sqrl_uart_recv;

  logic clk;
  logic reset;
  logic uart_rx;
  int   cyc;
  int   n_chk;
  int   n_fail;

  sqrl_uart_recv_if rx_if ();

  sqrl_uart_recv #(
    .comm_clk_frequency (16),
    .baud_rate          (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rx (uart_rx),
    .rx_if   (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  int         nb_t[$];
  logic [7:0] nb_b[$];
  int         fe_t[$];
  int         overlap_cnt;
  int         repeat_cnt;
  logic       prev_strobe;

  initial begin
    overlap_cnt = 0;
    repeat_cnt  = 0;
    prev_strobe = 1'b0;
  end

  always @(negedge clk) begin
    if (rx_if.rx_new_byte) begin
      nb_t.push_back(cyc);
      nb_b.push_back(rx_if.rx_byte);
    end
    if (rx_if.rx_frame_err) fe_t.push_back(cyc);
    if (rx_if.rx_new_byte && rx_if.rx_frame_err) overlap_cnt++;
    if ((rx_if.rx_new_byte || rx_if.rx_frame_err) && prev_strobe) repeat_cnt++;
    prev_strobe = rx_if.rx_new_byte || rx_if.rx_frame_err;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    nb_t.delete();
    nb_b.delete();
    fe_t.delete();
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame, one line value per clock, starting on a falling edge.
  // stop_low > 0 holds the stop slot low for that many cycles.
  // glitch inverts one cycle at the centre of every data bit.
  task automatic send_frame(input logic [7:0] d, input int stop_low, input bit glitch);
    logic v;
    for (int i = 0; i < 144; i++) begin
      if (i < 16) begin
        v = 1'b0;
      end else begin
        v = d[i / 16 - 1];
        if (glitch && (i % 16) == 8) v = ~v;
      end
      uart_rx = v;
      @(negedge clk);
    end
    if (stop_low > 0) begin
      uart_rx = 1'b0;
      repeat (stop_low) @(negedge clk);
      uart_rx = 1'b1;
    end else begin
      uart_rx = 1'b1;
      repeat (16) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    bit         glitch;
    int         exp_nb;
    int         exp_fe;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int         t0;
    logic [7:0] glitch_exp;

    n_chk  = 0;
    n_fail = 0;

`ifdef SQRL_UART_RX_MAJORITY_EN
    glitch_exp = 8'h96;
`else
    glitch_exp = 8'h69;
`endif
    //           data   stop_low glitch nb fe byte
    vecs[0] = '{8'h3C, 40,      1'b0,  0, 1, 8'hA5};
    vecs[1] = '{8'h5A, 0,       1'b0,  1, 0, 8'h5A};
    vecs[2] = '{8'h96, 0,       1'b1,  1, 0, glitch_exp};
    vecs[3] = '{8'h01, 0,       1'b0,  1, 0, 8'h01};
    vecs[4] = '{8'h80, 0,       1'b0,  1, 0, 8'h80};

    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_new_byte", 32'(rx_if.rx_new_byte), 32'd0);
    chk("reset_frame_err", 32'(rx_if.rx_frame_err), 32'd0);
    chk("reset_busy", 32'(rx_if.rx_busy), 32'd0);
    chk("reset_byte", 32'(rx_if.rx_byte), 32'h00);
    reset = 1'b0;
    idle(20);

    // Single frame 0xA5 and strobe latency.
    clear_mon();
    t0 = cyc + 1;
    send_frame(8'hA5, 0, 1'b0);
    idle(30);
    chk("a5_count", 32'(nb_t.size()), 32'd1);
    chk("a5_byte", 32'(nb_b.size() > 0 ? nb_b[0] : 8'hxx), 32'hA5);
    chk("a5_latency", 32'(nb_t.size() > 0 ? nb_t[0] - t0 : -1), 32'd154);
    chk("a5_hold", 32'(rx_if.rx_byte), 32'hA5);
    chk("a5_no_err", 32'(fe_t.size()), 32'd0);

    // Table of single frames, including framing error and glitched data.
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      send_frame(vecs[i].data, vecs[i].stop_low, vecs[i].glitch);
      idle(40);
      chk($sformatf("vec%0d_nb", i), 32'(nb_t.size()), 32'(vecs[i].exp_nb));
      chk($sformatf("vec%0d_fe", i), 32'(fe_t.size()), 32'(vecs[i].exp_fe));
      chk($sformatf("vec%0d_byte", i), 32'(rx_if.rx_byte), 32'(vecs[i].exp_byte));
      chk($sformatf("vec%0d_busy", i), 32'(rx_if.rx_busy), 32'd0);
    end

    // Back-to-back 0x00 then 0xFF with no idle gap.
    clear_mon();
    send_frame(8'h00, 0, 1'b0);
    send_frame(8'hFF, 0, 1'b0);
    idle(40);
    chk("b2b_count", 32'(nb_t.size()), 32'd2);
    chk("b2b_first", 32'(nb_b.size() > 0 ? nb_b[0] : 8'hxx), 32'h00);
    chk("b2b_second", 32'(nb_b.size() > 1 ? nb_b[1] : 8'hxx), 32'hFF);
    chk("b2b_spacing", 32'(nb_t.size() > 1 ? nb_t[1] - nb_t[0] : -1), 32'd160);

    // Three-cycle low pulse: false start rejected at the start sample.
    clear_mon();
    t0 = cyc + 1;
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    while (cyc < t0 + 9) @(negedge clk);
    chk("pulse_busy_at_sample", 32'(rx_if.rx_busy), 32'd1);
    @(negedge clk);
    chk("pulse_busy_after", 32'(rx_if.rx_busy), 32'd0);
    idle(30);
    chk("pulse_no_strobe", 32'(nb_t.size() + fe_t.size()), 32'd0);
    chk("pulse_byte_kept", 32'(rx_if.rx_byte), 32'hFF);

    // Reset in the middle of data bit 4, then a clean 0x81.
    clear_mon();
    for (int i = 0; i < 88; i++) begin
      uart_rx = (i < 16) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    chk("rst_mid_busy_before", 32'(rx_if.rx_busy), 32'd1);
    reset   = 1'b1;
    uart_rx = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(rx_if.rx_busy), 32'd0);
    chk("rst_mid_byte", 32'(rx_if.rx_byte), 32'h00);
    repeat (4) @(negedge clk);
    chk("rst_mid_new_byte", 32'(rx_if.rx_new_byte), 32'd0);
    chk("rst_mid_frame_err", 32'(rx_if.rx_frame_err), 32'd0);
    reset = 1'b0;
    idle(200);
    chk("rst_no_strobe", 32'(nb_t.size() + fe_t.size()), 32'd0);
    send_frame(8'h81, 0, 1'b0);
    idle(40);
    chk("rst_after_count", 32'(nb_t.size()), 32'd1);
    chk("rst_after_byte", 32'(rx_if.rx_byte), 32'h81);

    chk("strobe_overlap", 32'(overlap_cnt), 32'd0);
    chk("strobe_repeat", 32'(repeat_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrl_uart_recv.md
# sqrl_uart_recv

UART receiver for the sqrl comm-clock domain; it is the receive side of our 8N1 serial link. It synchronises the asynchronous `uart_rx` line, finds start bits, samples the eight data bits (LSB first) and the stop bit at bit centres, and presents each good byte as a one-cycle strobe. It sits between the board RX pin and the command parser, sharing baud parameters with the link transmitter.

## Interface

- `comm_clk_frequency`, default 100000000: clock frequency in Hz.
- `baud_rate`, default 115200: line rate in bits per second.
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `uart_rx` input 1: asynchronous serial line. Idles high.
- `rx_new_byte` output 1: one-cycle strobe. A valid byte is on `rx_byte`.
- `rx_byte` output 8: last good byte. It holds its value until the next good byte.
- `rx_frame_err` output 1: one-cycle strobe. The stop bit was sampled low.
- `rx_busy` output 1: high whenever the state is not IDLE.

## Operation

- Derived constants, all 16 bits wide:
  - `baud_delay = comm_clk_frequency/baud_rate - 1`.
  - `half_delay = baud_delay >> 1`.
  - `baud_delay >= 4` is required; elaborate with an error otherwise.
- `uart_rx` passes through a 2-flop synchroniser. Both flops reset to 1. The logic uses only its output, `rx_s`.
- One 16-bit counter `cnt`.
  - It increments every cycle outside IDLE.
  - It clears on every state transition and after every data-bit sample.
- States:
  - IDLE: `cnt` = 0. If `rx_s` = 0, go to START.
  - START: when `cnt == half_delay`, sample. If the sample is 0, clear `cnt` and go to DATA with `bit_idx` = 0. If it is 1, the start was a glitch: go to IDLE with no strobe.
  - DATA: when `cnt == baud_delay`, shift the sample into bit `bit_idx` (LSB first) and clear `cnt`. After `bit_idx` = 7, go to STOP.
  - STOP: when `cnt == baud_delay`, sample.
    - Sample 1: `rx_byte` is loaded with the shift register and `rx_new_byte` = 1 on the next cycle. Go to IDLE.
    - Sample 0: `rx_frame_err` = 1 on the next cycle, and `rx_byte` is unchanged. Go to WAIT_IDLE.
  - WAIT_IDLE (break/framing recovery): stay until `rx_s` = 1, then go to IDLE. A held-low line produces exactly one `rx_frame_err`.
- `rx_new_byte` and `rx_frame_err` are never high together and are never high two cycles in a row.
- The block has no backpressure: the consumer must take `rx_byte` on the strobe. The next strobe comes at least 10 bit times later.
- Reset while a frame is in progress: reset takes effect immediately, the partial byte is discarded, and neither strobe fires.
- Reset values:
  - `rx_new_byte` = 0, `rx_frame_err` = 0, `rx_busy` = 0.
  - `rx_byte` = 8'h00.
  - State IDLE, `cnt` = 0, synchroniser flops = 1.

## Timing

- Cycle numbering: cycle 0 is the first cycle in which the synchroniser's first flop has captured `uart_rx` = 0. `rx_s` = 0 at cycle 1.
- IDLE sees the low at cycle 1 and enters START at cycle 2 with `cnt` = 0.
- Start-bit sample: cycle 2 + `half_delay`.
- Data bit k sample: cycle 2 + `half_delay` + (k+1)·(`baud_delay`+1).
- Stop-bit sample: cycle 2 + `half_delay` + 9·(`baud_delay`+1).
- Strobe: one cycle after the stop-bit sample, when the state is back in IDLE.
- A start bit immediately following the stop bit is accepted, because IDLE checks `rx_s` on its first cycle.

## Configuration

- `SQRL_UART_RX_MAJORITY_EN` defined:
  - A 3-bit history of `rx_s` samples is kept.
  - Every sample point (start, data, stop) uses the majority of `rx_s` at the sample cycle and the two cycles before it.
  - Cycle timing is identical to the undefined case.
  - A single-cycle glitch at a sample point is rejected.
- `SQRL_UART_RX_MAJORITY_EN` undefined: each sample point uses the single `rx_s` value at that cycle.

## Structure

- Package `sqrl_uart_pkg`:
  - State enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - Function `uart_baud_delay(freq, baud)` returning 16 bits, shared with the transmitter.
  - Constant `UART_DATA_BITS` = 8.
- Sub-module `sqrl_uart_sync`: a 2-flop synchroniser with a reset value parameter, here 1.

## Test plan

All scenarios use `comm_clk_frequency` = 16 and `baud_rate` = 1, giving `baud_delay` = 15 and `half_delay` = 7.

- Send 0xA5 as 8N1 with 16-cycle bits → one `rx_new_byte`, `rx_byte` = 8'hA5. The strobe comes at cycle 2+7+9·16+1 = 154 after cycle 0.
- Send 0x00, then 0xFF back-to-back with no idle gap → two strobes exactly 160 cycles apart, values 8'h00 then 8'hFF.
- 3-cycle low pulse on an idle line → no strobe, `rx_busy` returns to 0 at start-sample time, `rx_byte` is unchanged.
- Frame 0x3C with the stop bit held low for 40 cycles, then high → one `rx_frame_err`, no `rx_new_byte`, `rx_byte` keeps its previous value, and the next valid frame 0x5A is received.
- Assert `reset` during data bit 4 of a frame, release it, then send 0x81 → no strobe from the aborted frame, 0x81 is received correctly, and all outputs are at reset values while `reset` is high.
- With `SQRL_UART_RX_MAJORITY_EN` defined, inject a 1-cycle inverted glitch at the centre of each data bit of 0x96 → `rx_byte` = 8'h96. Without the macro, the same stimulus yields 8'h69.
